ddfs_sweep_ctrl: RTL and testbench

DDFS_SWEEP_CTRL -- requirements
Module: ddfs_sweep_ctrl

---
 rtl/ddfs_sweep_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_ddfs_sweep_ctrl.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddfs_sweep_ctrl.sv
// DDFS sweep controller: streams a 256-entry amplitude table into the
// DDFS RAM, then steps the carrier word through a linear frequency sweep.
//
// Ports:
//   clk, reset            clock, async active-high reset
//   start, abort          start pulse (IDLE only), abort level
//   f_start, f_step       initial carrier word, signed per-step increment
//   n_steps, dwell        step count, cycles-per-step minus one
//   pha_in, env_in        phase offset and envelope applied during sweep
//   tbl_valid/ready/data  amplitude-table stream handshake
//   p2a_we/waddr/din      amplitude RAM write port
//   fccw, focw, pha, env  DDFS control words
//   busy, done            not-idle flag, end-of-sweep pulse
module ddfs_sweep_ctrl #(
  parameter int PW = 30,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic [PW-1:0] f_start,
  input  logic [PW-1:0] f_step,
  input  logic [DW-1:0] n_steps,
  input  logic [DW-1:0] dwell,
  input  logic [PW-1:0] pha_in,
  input  logic [15:0]   env_in,
  input  logic          tbl_valid,
  input  logic [15:0]   tbl_data,
  output logic          tbl_ready,
  output logic          p2a_we,
  output logic [7:0]    p2a_waddr,
  output logic [15:0]   p2a_din,
  output logic [PW-1:0] fccw,
  output logic [PW-1:0] focw,
  output logic [PW-1:0] pha,
  output logic [15:0]   env,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SWEEP,
    FINISH
  } state_e;

  state_e state_q, state_d;

  logic [7:0]    lcnt_q, lcnt_d;
  logic [PW-1:0] fstart_q, fstart_d;
  logic [PW-1:0] fstep_q, fstep_d;
  logic [DW-1:0] nstep_q, nstep_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [PW-1:0] phal_q, phal_d;
  logic [15:0]   envl_q, envl_d;
  logic [DW-1:0] k_q, k_d;
  logic [DW-1:0] dcnt_q, dcnt_d;

  logic [PW-1:0] fccw_q, fccw_d;
  logic [PW-1:0] pha_q, pha_d;
  logic [15:0]   env_q, env_d;
  logic          we_q, we_d;
  logic [7:0]    waddr_q, waddr_d;
  logic [15:0]   din_q, din_d;
  logic          done_q, done_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      lcnt_q   <= '0;
      fstart_q <= '0;
      fstep_q  <= '0;
      nstep_q  <= '0;
      dwell_q  <= '0;
      phal_q   <= '0;
      envl_q   <= '0;
      k_q      <= '0;
      dcnt_q   <= '0;
      fccw_q   <= '0;
      pha_q    <= '0;
      env_q    <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      din_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lcnt_q   <= lcnt_d;
      fstart_q <= fstart_d;
      fstep_q  <= fstep_d;
      nstep_q  <= nstep_d;
      dwell_q  <= dwell_d;
      phal_q   <= phal_d;
      envl_q   <= envl_d;
      k_q      <= k_d;
      dcnt_q   <= dcnt_d;
      fccw_q   <= fccw_d;
      pha_q    <= pha_d;
      env_q    <= env_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      din_q    <= din_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    lcnt_d   = lcnt_q;
    fstart_d = fstart_q;
    fstep_d  = fstep_q;
    nstep_d  = nstep_q;
    dwell_d  = dwell_q;
    phal_d   = phal_q;
    envl_d   = envl_q;
    k_d      = k_q;
    dcnt_d   = dcnt_q;
    fccw_d   = fccw_q;
    pha_d    = pha_q;
    env_d    = env_q;
    we_d     = 1'b0;
    waddr_d  = waddr_q;
    din_d    = din_q;
    done_d   = 1'b0;

    // Abort beats every transition, including a final table word or
    // the last step boundary landing in the same cycle.
    if (abort) begin
      state_d = IDLE;
      fccw_d  = '0;
      pha_d   = '0;
      env_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          fccw_d = '0;
          pha_d  = '0;
          env_d  = '0;
          if (start) begin
            state_d  = LOAD;
            lcnt_d   = '0;
            fstart_d = f_start;
            fstep_d  = f_step;
            nstep_d  = n_steps;
            dwell_d  = dwell;
            phal_d   = pha_in;
            envl_d   = env_in;
          end
        end
        LOAD: begin
          if (tbl_valid) begin
            we_d    = 1'b1;
            waddr_d = lcnt_q;
            din_d   = tbl_data;
            lcnt_d  = lcnt_q + 8'd1;
            if (lcnt_q == 8'hFF) begin
              state_d = SWEEP;
              fccw_d  = fstart_q;
              pha_d   = phal_q;
              env_d   = envl_q;
              k_d     = '0;
              dcnt_d  = '0;
            end
          end
        end
        SWEEP: begin
          if (nstep_q == '0) begin
            state_d = FINISH;
            env_d   = '0;
            done_d  = 1'b1;
          end else if (dcnt_q == dwell_q) begin
            dcnt_d = '0;
            k_d    = k_q + DW'(1);
            if ((k_q + DW'(1)) == nstep_q) begin
              state_d = FINISH;
              env_d   = '0;
              done_d  = 1'b1;
            end else begin
              fccw_d = fccw_q + fstep_q;
            end
          end else begin
            dcnt_d = dcnt_q + DW'(1);
          end
        end
        FINISH: begin
          state_d = IDLE;
          fccw_d  = '0;
          pha_d   = '0;
          env_d   = '0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign tbl_ready = (state_q == LOAD);
  assign busy      = (state_q != IDLE);
  assign p2a_we    = we_q;
  assign p2a_waddr = waddr_q;
  assign p2a_din   = din_q;
  assign fccw      = fccw_q;
  // Offset word reserved for a future FSK mode.
  assign focw      = '0;
  assign pha       = pha_q;
  assign env       = env_q;
  assign done      = done_q;

endmodule

// File: tb/tb_ddfs_sweep_ctrl.sv
// Directed bench for ddfs_sweep_ctrl: table load, backpressure,
// sweep stepping, wrap, abort and reset scenarios.
module tb_ddfs_sweep_ctrl;
  localparam int PW = 30;
  localparam int DW = 16;

  logic          clk;
  logic          reset;
  logic          start;
  logic          abort;
  logic [PW-1:0] f_start;
  logic [PW-1:0] f_step;
  logic [DW-1:0] n_steps;
  logic [DW-1:0] dwell;
  logic [PW-1:0] pha_in;
  logic [15:0]   env_in;
  logic          tbl_valid;
  logic [15:0]   tbl_data;
  logic          tbl_ready;
  logic          p2a_we;
  logic [7:0]    p2a_waddr;
  logic [15:0]   p2a_din;
  logic [PW-1:0] fccw;
  logic [PW-1:0] focw;
  logic [PW-1:0] pha;
  logic [15:0]   env;
  logic          busy;
  logic          done;

  int vec = 0;
  int errs = 0;

  ddfs_sweep_ctrl #(.PW(PW), .DW(DW)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .f_start(f_start), .f_step(f_step), .n_steps(n_steps),
    .dwell(dwell), .pha_in(pha_in), .env_in(env_in),
    .tbl_valid(tbl_valid), .tbl_data(tbl_data),
    .tbl_ready(tbl_ready), .p2a_we(p2a_we),
    .p2a_waddr(p2a_waddr), .p2a_din(p2a_din),
    .fccw(fccw), .focw(focw), .pha(pha), .env(env),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [PW-1:0] fs,
                          input logic [PW-1:0] st,
                          input logic [DW-1:0] n,
                          input logic [DW-1:0] dw,
                          input logic [PW-1:0] ph,
                          input logic [15:0]   en);
    f_start = fs; f_step = st; n_steps = n;
    dwell = dw; pha_in = ph; env_in = en;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic load_fast(input int cnt);
    tbl_valid = 1'b1;
    for (int i = 0; i < cnt; i++) begin
      tbl_data = 16'(i + 7);
      tick();
    end
    tbl_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    tbl_valid = 1'b0; tbl_data = '0;
    f_start = '0; f_step = '0; n_steps = '0;
    dwell = '0; pha_in = '0; env_in = '0;
    #12;
    vec++;
    if ({busy, done, tbl_ready, p2a_we} !== 4'b0) begin
      errs++;
      $display("FAIL reset_flags: got %b want 0000",
               {busy, done, tbl_ready, p2a_we});
    end
    vec++;
    if (fccw !== '0 || focw !== '0 || pha !== '0 || env !== '0) begin
      errs++;
      $display("FAIL reset_words: got fccw=%0h focw=%0h pha=%0h env=%0h want 0",
               fccw, focw, pha, env);
    end
    vec++;
    if (p2a_waddr !== 8'd0 || p2a_din !== 16'd0) begin
      errs++;
      $display("FAIL reset_ram: got addr=%0h din=%0h want 0",
               p2a_waddr, p2a_din);
    end
    reset = 1'b0;
    tick();
    vec++;
    if (busy !== 1'b0) begin
      errs++;
      $display("FAIL reset_idle: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_abort_idle();
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    vec++;
    if (busy !== 1'b0 || tbl_ready !== 1'b0) begin
      errs++;
      $display("FAIL abort_idle: got busy=%b ready=%b want 0 0",
               busy, tbl_ready);
    end
    tick();
    vec++;
    if (busy !== 1'b0) begin
      errs++;
      $display("FAIL abort_idle_hold: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_full_load();
    do_start(30'd5000, 30'd1, 16'd1, 16'd0, 30'h123, 16'h4000);
    vec++;
    if (busy !== 1'b1 || tbl_ready !== 1'b1 || p2a_we !== 1'b0) begin
      errs++;
      $display("FAIL load_enter: got busy=%b ready=%b we=%b want 1 1 0",
               busy, tbl_ready, p2a_we);
    end
    tbl_valid = 1'b1;
    for (int i = 0; i < 256; i++) begin
      tbl_data = 16'(i * 3);
      tick();
      vec++;
      if (p2a_we !== 1'b1 || p2a_waddr !== 8'(i) ||
          p2a_din !== 16'(i * 3) || tbl_ready !== (i < 255)) begin
        errs++;
        $display("FAIL load_word: got we=%b a=%0d d=%0d rdy=%b want 1 %0d %0d %b",
                 p2a_we, p2a_waddr, p2a_din, tbl_ready, i, i * 3, i < 255);
      end
    end
    tbl_valid = 1'b0;
    vec++;
    if (busy !== 1'b1 || fccw !== 30'd5000 || pha !== 30'h123 ||
        env !== 16'h4000) begin
      errs++;
      $display("FAIL load_sweep: got busy=%b fccw=%0d pha=%0h env=%0h want 1 5000 123 4000",
               busy, fccw, pha, env);
    end
    tick();
    vec++;
    if (done !== 1'b1 || env !== 16'd0 || fccw !== 30'd5000 ||
        p2a_we !== 1'b0) begin
      errs++;
      $display("FAIL load_finish: got done=%b env=%0h fccw=%0d we=%b want 1 0 5000 0",
               done, env, fccw, p2a_we);
    end
    tick();
    vec++;
    if (done !== 1'b0 || busy !== 1'b0 || fccw !== '0 || pha !== '0) begin
      errs++;
      $display("FAIL load_idle: got done=%b busy=%b fccw=%0d pha=%0h want 0 0 0 0",
               done, busy, fccw, pha);
    end
  endtask

  task automatic test_backpressure();
    int exp_a;
    int cyc;
    logic v;
    exp_a = 0;
    cyc = 0;
    do_start(30'd77, 30'd0, 16'd0, 16'd5, 30'd9, 16'h7FFF);
    while (exp_a < 256 && cyc < 3000) begin
      v = ($urandom_range(0, 2) != 0);
      tbl_valid = v;
      tbl_data = 16'h5A00 ^ 16'(exp_a);
      tick();
      cyc++;
      if (v) begin
        vec++;
        if (p2a_we !== 1'b1 || p2a_waddr !== 8'(exp_a) ||
            p2a_din !== (16'h5A00 ^ 16'(exp_a))) begin
          errs++;
          $display("FAIL bp_write: got we=%b a=%0d d=%0h want 1 %0d %0h",
                   p2a_we, p2a_waddr, p2a_din, exp_a,
                   16'h5A00 ^ 16'(exp_a));
        end
        exp_a++;
      end else begin
        vec++;
        if (p2a_we !== 1'b0 || tbl_ready !== 1'b1) begin
          errs++;
          $display("FAIL bp_stall: got we=%b rdy=%b want 0 1",
                   p2a_we, tbl_ready);
        end
      end
    end
    tbl_valid = 1'b0;
    if (exp_a < 256) begin
      vec++;
      errs++;
      $display("FAIL bp_timeout: got %0d transfers want 256", exp_a);
      abort = 1'b1;
      tick();
      abort = 1'b0;
    end else begin
      vec++;
      if (tbl_ready !== 1'b0 || fccw !== 30'd77 || env !== 16'h7FFF) begin
        errs++;
        $display("FAIL bp_sweep: got rdy=%b fccw=%0d env=%0h want 0 77 7fff",
                 tbl_ready, fccw, env);
      end
      tick();
      vec++;
      if (done !== 1'b1 || fccw !== 30'd77 || env !== 16'd0) begin
        errs++;
        $display("FAIL nsteps0_finish: got done=%b fccw=%0d env=%0h want 1 77 0",
                 done, fccw, env);
      end
      tick();
      vec++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        errs++;
        $display("FAIL nsteps0_idle: got busy=%b done=%b want 0 0",
                 busy, done);
      end
    end
  endtask

  task automatic test_sweep();
    logic [PW-1:0] ef;
    do_start(30'd1000, 30'h3FFFFFF6, 16'd4, 16'd2, 30'h55, 16'h1234);
    load_fast(256);
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < 3; c++) begin
        ef = PW'(1000 - 10 * s);
        vec++;
        if (fccw !== ef || env !== 16'h1234 || pha !== 30'h55 ||
            done !== 1'b0 || busy !== 1'b1 || focw !== '0) begin
          errs++;
          $display("FAIL sweep_step%0d_%0d: got fccw=%0d env=%0h pha=%0h done=%b want %0d 1234 55 0",
                   s, c, fccw, env, pha, done, ef);
        end
        start = (s == 1 && c == 1);
        tick();
      end
    end
    start = 1'b0;
    vec++;
    if (done !== 1'b1 || env !== 16'd0 || fccw !== 30'd970) begin
      errs++;
      $display("FAIL sweep_finish: got done=%b env=%0h fccw=%0d want 1 0 970",
               done, env, fccw);
    end
    tick();
    vec++;
    if (done !== 1'b0 || busy !== 1'b0 || fccw !== '0) begin
      errs++;
      $display("FAIL sweep_idle: got done=%b busy=%b fccw=%0d want 0 0 0",
               done, busy, fccw);
    end
  endtask

  task automatic test_wrap();
    do_start(30'h3FFFFFFF, 30'd2, 16'd2, 16'd0, 30'd0, 16'h0100);
    load_fast(256);
    vec++;
    if (fccw !== 30'h3FFFFFFF) begin
      errs++;
      $display("FAIL wrap_first: got fccw=%0h want 3fffffff", fccw);
    end
    tick();
    vec++;
    if (fccw !== 30'd1 || done !== 1'b0) begin
      errs++;
      $display("FAIL wrap_second: got fccw=%0h done=%b want 1 0", fccw, done);
    end
    tick();
    vec++;
    if (done !== 1'b1 || fccw !== 30'd1) begin
      errs++;
      $display("FAIL wrap_finish: got done=%b fccw=%0h want 1 1", done, fccw);
    end
    tick();
  endtask

  task automatic test_abort_last();
    do_start(30'd321, 30'd4, 16'd1, 16'd1, 30'd3, 16'h2222);
    load_fast(255);
    tbl_valid = 1'b1;
    tbl_data = 16'hBEEF;
    abort = 1'b1;
    tick();
    tbl_valid = 1'b0;
    abort = 1'b0;
    vec++;
    if (busy !== 1'b0 || done !== 1'b0 || fccw !== '0 || env !== '0) begin
      errs++;
      $display("FAIL abort_last: got busy=%b done=%b fccw=%0d env=%0h want 0 0 0 0",
               busy, done, fccw, env);
    end
    tick();
    vec++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errs++;
      $display("FAIL abort_stay: got busy=%b done=%b want 0 0", busy, done);
    end
    do_start(30'd40, 30'd5, 16'd1, 16'd1, 30'd3, 16'h2222);
    load_fast(256);
    vec++;
    if (fccw !== 30'd40 || env !== 16'h2222) begin
      errs++;
      $display("FAIL restart_sweep: got fccw=%0d env=%0h want 40 2222",
               fccw, env);
    end
    tick();
    vec++;
    if (fccw !== 30'd40 || done !== 1'b0) begin
      errs++;
      $display("FAIL restart_dwell: got fccw=%0d done=%b want 40 0",
               fccw, done);
    end
    tick();
    vec++;
    if (done !== 1'b1) begin
      errs++;
      $display("FAIL restart_done: got done=%b want 1", done);
    end
    tick();
  endtask

  task automatic test_reset_mid_sweep();
    do_start(30'd500, 30'd7, 16'd4, 16'd1, 30'h77, 16'h0F0F);
    load_fast(256);
    repeat (4) tick();
    vec++;
    if (fccw !== 30'd514) begin
      errs++;
      $display("FAIL rst_k2: got fccw=%0d want 514", fccw);
    end
    #2;
    reset = 1'b1;
    #1;
    vec++;
    if (fccw !== '0 || pha !== '0 || env !== '0 || busy !== 1'b0 ||
        done !== 1'b0 || tbl_ready !== 1'b0 || p2a_we !== 1'b0 ||
        p2a_waddr !== 8'd0 || p2a_din !== 16'd0) begin
      errs++;
      $display("FAIL rst_async: got fccw=%0d pha=%0h env=%0h busy=%b addr=%0h din=%0h want all 0",
               fccw, pha, env, busy, p2a_waddr, p2a_din);
    end
    #2;
    reset = 1'b0;
    tick();
    tick();
    vec++;
    if (busy !== 1'b0) begin
      errs++;
      $display("FAIL rst_wait: got busy=%b want 0", busy);
    end
    do_start(30'd200, 30'd3, 16'd2, 16'd0, 30'd1, 16'h0001);
    load_fast(256);
    vec++;
    if (fccw !== 30'd200) begin
      errs++;
      $display("FAIL rst_rerun0: got fccw=%0d want 200", fccw);
    end
    tick();
    vec++;
    if (fccw !== 30'd203) begin
      errs++;
      $display("FAIL rst_rerun1: got fccw=%0d want 203", fccw);
    end
    tick();
    vec++;
    if (done !== 1'b1 || fccw !== 30'd203) begin
      errs++;
      $display("FAIL rst_rerun_done: got done=%b fccw=%0d want 1 203",
               done, fccw);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_abort_idle();
    test_full_load();
    test_backpressure();
    test_sweep();
    test_wrap();
    test_abort_last();
    test_reset_mid_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
